// File: rtl/ahb_imem_slave.sv
// AHB-Lite word-organised memory slave with programmable wait states and a two-cycle ERROR response.
// Latency: WAIT_STATES+1 data-phase cycles per OKAY transfer, 2 per ERROR; stalls the bus via hreadyout.
// Backpressure: address phases are only taken while hready is high; reads forward a write committing on the same edge.
module ahb_imem_slave #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);
    localparam int         AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t        state;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] lat_idx;
    logic [1:0]    lat_off;
    logic [1:0]    lat_size;
    logic          lat_write;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          legal;
    logic          align_ok;
    logic [AW-1:0] new_idx;
    logic [3:0]    be;
    logic          wr_commit;
    logic [31:0]   wr_word;
    logic [31:0]   fwd_word;
    logic          unused_ok;

    assign accept    = hsel & hready & htrans[1];
    assign new_idx   = haddr[AW+1:2];
    assign unused_ok = &{1'b0, htrans[0]};

    always_comb begin
        align_ok = 1'b1;
        if (hsize == 3'd1)
            align_ok = ~haddr[0];
        else if (hsize == 3'd2)
            align_ok = (haddr[1:0] == 2'b00);
        legal = (hsize <= 3'd2) && align_ok && (haddr[31:AW+2] == BASE_ADDR[31:AW+2]);
    end

    // Merged word for the write being committed at the end of the current DATA cycle.
    always_comb begin
        be = 4'b0000;
        case (lat_size)
            2'd0:    be[lat_off] = 1'b1;
            2'd1:    be = lat_off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        wr_word = mem[lat_idx];
        for (int i = 0; i < 4; i++)
            if (be[i])
                wr_word[8*i +: 8] = hwdata[8*i +: 8];
    end

    assign wr_commit = (state == S_DATA) && lat_write;
    assign fwd_word  = (wr_commit && (lat_idx == new_idx)) ? wr_word : mem[new_idx];

    always_ff @(posedge clk) begin
        if (!reset && wr_commit)
            mem[lat_idx] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= 32'd0;
            lat_idx   <= '0;
            lat_off   <= 2'd0;
            lat_size  <= 2'd0;
            lat_write <= 1'b0;
        end else begin
            hrdata <= 32'd0;
            case (state)
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state     <= S_DATA;
                        hreadyout <= 1'b1;
                        if (!lat_write)
                            hrdata <= mem[lat_idx];
                    end
                end
                S_ERR1: begin
                    state     <= S_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        lat_idx   <= new_idx;
                        lat_off   <= haddr[1:0];
                        lat_size  <= hsize[1:0];
                        lat_write <= hwrite;
                        if (!legal) begin
                            state     <= S_ERR1;
                            hreadyout <= 1'b0;
                            hresp     <= 1'b1;
                        end else if (WS != 4'd0) begin
                            state     <= S_WAIT;
                            wait_cnt  <= WS;
                            hreadyout <= 1'b0;
                            hresp     <= 1'b0;
                        end else begin
                            state     <= S_DATA;
                            hreadyout <= 1'b1;
                            hresp     <= 1'b0;
                            if (!hwrite)
                                hrdata <= fwd_word;
                        end
                    end else begin
                        state     <= S_IDLE;
                        hreadyout <= 1'b1;
                        hresp     <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_imem_slave.sv
// Bench for ahb_imem_slave: three instances (0, 2 and 3 wait states) driven one at a time,
// checked against a byte-addressed memory model.
module tb_ahb_imem_slave;
    localparam int NDUT  = 3;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = 32'd0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [31:0] hwdata = 32'd0;
    int          tgt = 0;

    logic [NDUT-1:0] hsel_v;
    logic [NDUT-1:0] hreadyout_v;
    logic [NDUT-1:0] hresp_v;
    logic [31:0]     hrdata_v [NDUT];

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] mb [int];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        assign hsel_v[g] = hsel && (tgt == g);
        ahb_imem_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .BASE_ADDR(32'h0)) u_dut (
            .clk(clk), .reset(reset), .hsel(hsel_v[g]), .haddr(haddr), .htrans(htrans),
            .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hreadyout_v[g]),
            .hrdata(hrdata_v[g]), .hreadyout(hreadyout_v[g]), .hresp(hresp_v[g]));
    end

    function automatic int ws_of(int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    function automatic bit model_legal(logic [31:0] a, int sz);
        if (sz > 2) return 1'b0;
        if ((a % (32'd1 << sz)) != 0) return 1'b0;
        return a < 32'(4 * DEPTH);
    endfunction

    function automatic logic [31:0] model_read(int k, logic [31:0] a);
        logic [31:0] w;
        int base = k * 65536 + int'(a & ~32'd3);
        for (int b = 0; b < 4; b++)
            w[8*b +: 8] = mb.exists(base + b) ? mb[base + b] : 8'hxx;
        return w;
    endfunction

    task automatic model_write(int k, logic [31:0] a, int sz, logic [31:0] wd);
        logic [31:0] ad;
        for (int b = 0; b < (1 << sz); b++) begin
            ad = a + 32'(b);
            mb[k * 65536 + int'(ad)] = wd[8*int'(ad[1:0]) +: 8];
        end
    endtask

    // One non-pipelined transfer, entered and left at a falling edge; returns observations only.
    task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output logic rsp,
                        output int waits, output bit low_resp, output bit low_rd_nz);
        tgt = k; hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
        @(posedge clk); @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwdata = wd;
        waits = 0; low_resp = 1'b0; low_rd_nz = 1'b0;
        while (hreadyout_v[k] !== 1'b1 && waits < 40) begin
            waits++;
            if (hresp_v[k] === 1'b1) low_resp = 1'b1;
            if (hrdata_v[k] !== 32'd0) low_rd_nz = 1'b1;
            @(negedge clk);
        end
        rd = hrdata_v[k]; rsp = hresp_v[k];
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            n_cmp += 3;
            if (hreadyout_v[k] !== 1'b1) begin n_bad++; $display("FAIL reset_hreadyout[%0d]: got %b want 1", k, hreadyout_v[k]); end
            if (hresp_v[k] !== 1'b0) begin n_bad++; $display("FAIL reset_hresp[%0d]: got %b want 0", k, hresp_v[k]); end
            if (hrdata_v[k] !== 32'd0) begin n_bad++; $display("FAIL reset_hrdata[%0d]: got %h want 0", k, hrdata_v[k]); end
        end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        tgt = 0; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (hreadyout_v[0] !== 1'b1) begin n_bad++; $display("FAIL b2b_write_ready: got %b want 1", hreadyout_v[0]); end
        hwrite = 1'b0; hwdata = 32'hDEAD_BEEF;
        @(posedge clk); @(negedge clk);
        hsel = 1'b0; htrans = 2'b00;
        model_write(0, 32'h10, 2, 32'hDEAD_BEEF);
        n_cmp += 3;
        if (hreadyout_v[0] !== 1'b1) begin n_bad++; $display("FAIL b2b_read_ready: got %b want 1", hreadyout_v[0]); end
        if (hresp_v[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_read_resp: got %b want 0", hresp_v[0]); end
        if (hrdata_v[0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL b2b_read_data: got %h want deadbeef", hrdata_v[0]); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic rsp; int w; bit lr, lz;
        xfer(0, 1'b1, 32'h20, 3'd2, 32'h1122_3344, rd, rsp, w, lr, lz);
        xfer(0, 1'b1, 32'h22, 3'd0, 32'h00AA_0000, rd, rsp, w, lr, lz);
        xfer(0, 1'b1, 32'h20, 3'd1, 32'h0000_5566, rd, rsp, w, lr, lz);
        model_write(0, 32'h20, 2, 32'h11AA_5566);
        xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, rd, rsp, w, lr, lz);
        n_cmp += 2;
        if (rd !== 32'h11AA_5566) begin n_bad++; $display("FAIL byte_lanes_data: got %h want 11aa5566", rd); end
        if (rsp !== 1'b0) begin n_bad++; $display("FAIL byte_lanes_resp: got %b want 0", rsp); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic rsp; int w; bit lr, lz; logic [31:0] v;
        v = $urandom;
        xfer(2, 1'b1, 32'h40, 3'd2, v, rd, rsp, w, lr, lz);
        model_write(2, 32'h40, 2, v);
        n_cmp++;
        if (w != 3) begin n_bad++; $display("FAIL ws_write_waits: got %0d want 3", w); end
        xfer(2, 1'b0, 32'h40, 3'd2, 32'h0, rd, rsp, w, lr, lz);
        n_cmp += 4;
        if (w != 3) begin n_bad++; $display("FAIL ws_read_waits: got %0d want 3", w); end
        if (lz) begin n_bad++; $display("FAIL ws_hrdata_during_wait: got nonzero want 0"); end
        if (rd !== model_read(2, 32'h40)) begin n_bad++; $display("FAIL ws_read_data: got %h want %h", rd, model_read(2, 32'h40)); end
        if (rsp !== 1'b0) begin n_bad++; $display("FAIL ws_read_resp: got %b want 0", rsp); end
        @(negedge clk);
        n_cmp++;
        if (hrdata_v[2] !== 32'd0) begin n_bad++; $display("FAIL ws_data_one_cycle: got %h want 0", hrdata_v[2]); end
    endtask

    task automatic test_error();
        logic [31:0] rd; logic rsp; int w; bit lr, lz;
        xfer(0, 1'b1, 32'h0, 3'd2, 32'h0BAD_F00D, rd, rsp, w, lr, lz);
        model_write(0, 32'h0, 2, 32'h0BAD_F00D);
        xfer(0, 1'b0, 32'h2, 3'd2, 32'h0, rd, rsp, w, lr, lz);
        n_cmp += 4;
        if (w != 1) begin n_bad++; $display("FAIL err_misalign_low_cycles: got %0d want 1", w); end
        if (!lr) begin n_bad++; $display("FAIL err_misalign_err1_resp: got 0 want 1"); end
        if (rsp !== 1'b1) begin n_bad++; $display("FAIL err_misalign_err2_resp: got %b want 1", rsp); end
        if (rd !== 32'd0) begin n_bad++; $display("FAIL err_misalign_hrdata: got %h want 0", rd); end
        @(negedge clk);
        n_cmp++;
        if (hresp_v[0] !== 1'b0) begin n_bad++; $display("FAIL err_after_resp: got %b want 0", hresp_v[0]); end
        xfer(0, 1'b1, 32'(4 * DEPTH), 3'd2, 32'hFFFF_FFFF, rd, rsp, w, lr, lz);
        n_cmp += 3;
        if (w != 1) begin n_bad++; $display("FAIL err_range_low_cycles: got %0d want 1", w); end
        if (!lr) begin n_bad++; $display("FAIL err_range_err1_resp: got 0 want 1"); end
        if (rsp !== 1'b1) begin n_bad++; $display("FAIL err_range_err2_resp: got %b want 1", rsp); end
        xfer(0, 1'b0, 32'h0, 3'd2, 32'h0, rd, rsp, w, lr, lz);
        n_cmp++;
        if (rd !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL err_word0_unchanged: got %h want 0badf00d", rd); end
    endtask

    task automatic test_idle_busy();
        logic [31:0] rd; logic rsp; int w; bit lr, lz;
        tgt = 0; hsel = 1'b1; htrans = 2'b01; hwrite = 1'b1; haddr = 32'h0; hsize = 3'd2; hwdata = 32'h5555_AAAA;
        @(posedge clk); @(negedge clk);
        n_cmp += 2;
        if (hreadyout_v[0] !== 1'b1) begin n_bad++; $display("FAIL busy_ready: got %b want 1", hreadyout_v[0]); end
        if (hresp_v[0] !== 1'b0) begin n_bad++; $display("FAIL busy_resp: got %b want 0", hresp_v[0]); end
        hsel = 1'b0; htrans = 2'b10;
        @(posedge clk); @(negedge clk);
        n_cmp += 2;
        if (hreadyout_v[0] !== 1'b1) begin n_bad++; $display("FAIL nosel_ready: got %b want 1", hreadyout_v[0]); end
        if (hresp_v[0] !== 1'b0) begin n_bad++; $display("FAIL nosel_resp: got %b want 0", hresp_v[0]); end
        htrans = 2'b00;
        @(posedge clk); @(negedge clk);
        xfer(0, 1'b0, 32'h0, 3'd2, 32'h0, rd, rsp, w, lr, lz);
        n_cmp++;
        if (rd !== model_read(0, 32'h0)) begin n_bad++; $display("FAIL idle_busy_no_write: got %h want %h", rd, model_read(0, 32'h0)); end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd; logic rsp; int w; bit lr, lz;
        xfer(1, 1'b1, 32'h30, 3'd2, 32'hA5A5_0F0F, rd, rsp, w, lr, lz);
        model_write(1, 32'h30, 2, 32'hA5A5_0F0F);
        tgt = 1; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2;
        @(posedge clk); @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h1234_5678;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (hreadyout_v[1] !== 1'b0) begin n_bad++; $display("FAIL rst_second_wait_ready: got %b want 0", hreadyout_v[1]); end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        n_cmp += 3;
        if (hreadyout_v[1] !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 1", hreadyout_v[1]); end
        if (hresp_v[1] !== 1'b0) begin n_bad++; $display("FAIL rst_mid_resp: got %b want 0", hresp_v[1]); end
        if (hrdata_v[1] !== 32'd0) begin n_bad++; $display("FAIL rst_mid_hrdata: got %h want 0", hrdata_v[1]); end
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        xfer(1, 1'b0, 32'h30, 3'd2, 32'h0, rd, rsp, w, lr, lz);
        n_cmp += 2;
        if (rd !== 32'hA5A5_0F0F) begin n_bad++; $display("FAIL rst_mid_prior_contents: got %h want a5a50f0f", rd); end
        if (w != 2) begin n_bad++; $display("FAIL rst_mid_read_waits: got %0d want 2", w); end
    endtask

    task automatic test_random(input int k, input int n);
        logic [31:0] rd; logic rsp; int w; bit lr, lz;
        logic [31:0] a, wd, exp_rd; int sz, r, off, word; bit wr, lg;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            xfer(k, 1'b1, 32'h100 + 32'(4 * i), 3'd2, wd, rd, rsp, w, lr, lz);
            model_write(k, 32'h100 + 32'(4 * i), 2, wd);
        end
        for (int i = 0; i < n; i++) begin
            word = $urandom_range(0, 15);
            sz = $urandom_range(0, 2);
            off = $urandom_range(0, 3);
            if (sz == 1) off = off & 2;
            if (sz == 2) off = 0;
            a = 32'h100 + 32'(4 * word + off);
            r = $urandom_range(0, 9);
            if (r == 0) sz = $urandom_range(3, 7);
            else if (r == 1) begin sz = 2; a = 32'h101 + 32'(4 * word); end
            else if (r == 2) a = ($urandom_range(0, 1) == 1) ? 32'hF000_0100 : 32'h1000 + 32'(4 * word);
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            lg = model_legal(a, sz);
            exp_rd = (lg && !wr) ? model_read(k, a) : 32'd0;
            xfer(k, wr, a, 3'(sz), wd, rd, rsp, w, lr, lz);
            if (lg && wr) model_write(k, a, sz, wd);
            n_cmp += 4;
            if (w != (lg ? ws_of(k) : 1)) begin n_bad++; $display("FAIL rnd%0d_waits #%0d a=%h sz=%0d: got %0d want %0d", k, i, a, sz, w, lg ? ws_of(k) : 1); end
            if (rsp !== !lg) begin n_bad++; $display("FAIL rnd%0d_resp #%0d a=%h: got %b want %b", k, i, a, rsp, !lg); end
            if (lr !== !lg) begin n_bad++; $display("FAIL rnd%0d_low_resp #%0d a=%h: got %b want %b", k, i, a, lr, !lg); end
            if (rd !== exp_rd) begin n_bad++; $display("FAIL rnd%0d_hrdata #%0d a=%h wr=%b: got %h want %h", k, i, a, wr, rd, exp_rd); end
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_byte_lanes();
        test_wait_states();
        test_error();
        test_idle_busy();
        test_reset_mid_write();
        test_random(0, 80);
        test_random(1, 50);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ahb_imem_slave.md
# ahb_imem_slave

AHB-Lite slave memory that answers the multicycle core's instruction-fetch and data transfers. It is the responder end of the bus driven by the fetch/execute stages: it registers each address phase, inserts a programmable number of wait states, and returns read data or commits write data. It also flags illegal transfers with the two-cycle AHB ERROR response. It sits between the AHB interconnect and a word-organised storage array.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two.
- WAIT_STATES, 1: hreadyout-low cycles inserted per OKAY data phase; range 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- hsel  in  1  slave select.
- haddr  in  32  byte address (address phase).
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  in  1  1 = write.
- hsize  in  3  0 = byte, 1 = half, 2 = word; any other value is illegal.
- hwdata  in  32  write data (data phase).
- hready  in  1  bus-level ready; qualifies the address phase.
- hrdata  out  32  read data.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.

## Operation
- A transfer is accepted when hsel & hready & htrans[1] are all 1 on a clock edge. On acceptance, latch haddr, hwrite and hsize, then enter the data phase.
- IDLE or BUSY with hsel=1, and any cycle with hsel=0, accept nothing. The next cycle responds OKAY with zero wait.
- Legality check at acceptance. A transfer is illegal if any of these holds:
  - hsize > 2;
  - haddr is misaligned for hsize (half: haddr[0]≠0; word: haddr[1:0]≠0);
  - haddr lies outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS).
- FSM states:
  - IDLE: hreadyout=1, hresp=0.
  - WAIT: hreadyout=0, hresp=0. A counter is loaded with WAIT_STATES on acceptance and decrements each cycle. Exit to DATA when it reaches 1.
  - DATA: hreadyout=1, hresp=0. This is the last cycle of an OKAY data phase.
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
- Transitions:
  - An accepted legal transfer goes to WAIT if WAIT_STATES>0, otherwise straight to DATA.
  - An accepted illegal transfer goes to ERR1, then ERR2. Illegal transfers ignore WAIT_STATES.
  - From DATA or ERR2, go to WAIT/DATA/ERR1 if a new transfer is accepted in that same cycle (pipelined back-to-back), otherwise go to IDLE.
- Address phases presented while hreadyout=0 are not accepted, because hready is low.
- Read:
  - hrdata carries the full word at the latched word index, haddr[log2(DEPTH_WORDS)+1:2] − BASE_ADDR offset.
  - The value is valid in the DATA cycle.
  - hrdata is 0 in every cycle that is not a read DATA cycle.
- Write:
  - Committed on the clock edge that ends the DATA cycle, using hwdata sampled in that cycle.
  - Byte lanes are enabled per the latched hsize and haddr[1:0] (little-endian). Only enabled lanes change.
- Illegal transfers never modify the array. An illegal read returns hrdata=0.
- Read-after-write: a read whose DATA cycle directly follows a write DATA cycle to the same word returns the newly written bytes.

## Timing
- Reset values: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0. Array contents are not cleared.
- Reset asserted mid-transfer:
  - The next edge forces IDLE.
  - A pending write is discarded, including a reset in the DATA cycle itself.
  - The transfer is not resumed.
- OKAY latency, counted from the address-phase edge: the data phase lasts WAIT_STATES+1 cycles. WAIT_STATES=0 gives a single DATA cycle immediately after acceptance.
- ERROR latency: exactly two cycles (ERR1, ERR2).
- Sustained throughput with WAIT_STATES=0: one transfer per cycle.
- hresp never changes while hreadyout=0, except on entry to ERR1.

## Test plan
- Write then read, back-to-back, WAIT_STATES=0:
  - Stimulus: NONSEQ word write 0x0000_0010 ← 0xDEAD_BEEF, then a read of 0x10 pipelined in the next address phase.
  - Required: read DATA cycle hrdata=0xDEAD_BEEF, hresp=0, no hreadyout-low cycles.
- Byte lanes:
  - Stimulus: word write 0x20 ← 0x1122_3344, then byte write 0x22 ← 0x0000_AA00_00 lane2 (hwdata=0x00AA_0000), then half write 0x20 ← hwdata 0x0000_5566.
  - Required: read of 0x20 returns 0x11AA_5566.
- Wait states:
  - Stimulus: WAIT_STATES=3, single read.
  - Required: hreadyout low for exactly 3 cycles, then high for 1 cycle with valid hrdata.
- Error:
  - Stimulus: word read at 0x0000_0002.
  - Required: hreadyout=0/hresp=1 then hreadyout=1/hresp=1, hrdata=0.
  - Stimulus: write at BASE_ADDR+4*DEPTH_WORDS.
  - Required: same two-cycle ERROR; a later read of word 0 is unchanged.
- IDLE/BUSY:
  - Stimulus: htrans=BUSY with hsel=1, and htrans=NONSEQ with hsel=0.
  - Required: hreadyout=1, hresp=0, no array change.
- Reset mid-write:
  - Stimulus: WAIT_STATES=2, write 0x30 ← 0x1234_5678, reset asserted in the second WAIT cycle.
  - Required: outputs return to reset values the next cycle; a subsequent read of 0x30 returns the prior contents.
